punc_mem_arbiter: RTL
=====================

Name: punc_mem_arbiter

Overview:
- Sequences the single-port PUnC LC3 memory and shares it between two requesters: the control unit (fetch/load/store, "cpu" port) and the debug/loader port ("dbg" port).
- Non-pipelined, one access in flight at a time.
- CPU has fixed priority. A starvation guard forces a debug grant after STARVE_LIMIT consecutive lost arbitrations.
- Sits between PUnCControl/datapath and the memory macro, which has synchronous read with 1-cycle latency.

Parameters:
- AW, 16, address width.
- DW, 16, data width.
- STARVE_LIMIT, 4, number of consecutive CPU wins against a pending dbg_req after which dbg wins the next decision.
- CW, 3, starvation counter width; must satisfy 2^CW > STARVE_LIMIT.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset; rst=0 at a clk edge resets the block.
- cpu_req  in  1  CPU access request; held until cpu_gnt.
- cpu_we  in  1  1=write, 0=read.
- cpu_addr  in  AW  CPU address.
- cpu_wdata  in  DW  CPU write data.
- cpu_gnt  out  1  one-cycle pulse: CPU request accepted.
- cpu_done  out  1  one-cycle pulse: access complete (cpu_rdata valid for reads).
- cpu_rdata  out  DW  CPU read data; holds last value.
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_gnt, dbg_done, dbg_rdata: same as the cpu_* ports, for the debug requester.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; valid the cycle after mem_en with mem_we=0.

Behaviour:
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - Samples cpu_req and dbg_req.
  - If either is high, picks an owner, latches owner's we/addr/wdata into internal registers, and goes to ISSUE.
  - Otherwise stays in IDLE.
- ISSUE (1 cycle):
  - Registered outputs show gnt[owner]=1, mem_en=1, mem_we/mem_addr/mem_wdata = latched values.
  - Always goes to RESP.
- RESP (1 cycle):
  - mem_en=0.
  - For a read, owner's rdata register captures mem_rdata at the edge ending RESP.
  - For a write, rdata is unchanged.
  - Goes to IDLE; done[owner]=1 in the following cycle (registered).
- Timing, for req high in cycle N while in IDLE:
  - gnt and mem_en in N+1.
  - mem_rdata sampled in N+2.
  - done and rdata valid in N+3.
  - The block is back in IDLE in N+3 and can accept a new request that same cycle.
  - Maximum throughput is one access per 3 cycles.
- Handshake rules:
  - Requester holds req/we/addr/wdata stable until gnt.
  - Requester drops req in the gnt cycle unless it has a new access ready for the N+3 decision.
  - req is ignored in ISSUE and RESP.
- Arbitration:
  - Only cpu_req high: CPU wins. Only dbg_req high: dbg wins.
  - Both high: CPU wins if starve_cnt < STARVE_LIMIT; dbg wins otherwise.
- Starvation counter starve_cnt (CW bits):
  - +1 on each CPU win while dbg_req=1.
  - Cleared on any dbg win, or in IDLE when dbg_req=0.
  - Saturates at STARVE_LIMIT.
- Only the owner's gnt/done may pulse; the other requester's gnt/done stay 0.
- Reset (rst=0), including mid-operation:
  - state=IDLE, starve_cnt=0.
  - All gnt/done/mem_en/mem_we = 0.
  - mem_addr, mem_wdata, cpu_rdata, dbg_rdata = 0.
  - An in-flight access is abandoned with no done pulse; a write strobed in ISSUE before reset is allowed to have landed.
- Address wrap: none, addresses pass through unchanged. 16'hFFFF is a legal address.

Decomposition:
- Shared package/defines (Defines.v): state encodings ARB_IDLE=2'd0, ARB_ISSUE=2'd1, ARB_RESP=2'd2, owner encoding OWN_CPU=1'b0, OWN_DBG=1'b1, and default AW/DW.
- One natural sub-module: punc_starve_counter, a saturating counter with inc/clr/limit-reached output, parameterised by CW and STARVE_LIMIT.

Test Plan:
- CPU read: mem preloaded with [16'h3000]=16'hBEEF; cpu_req=1, we=0, addr=16'h3000 in cycle N -> cpu_gnt and mem_en=1 with mem_addr=16'h3000 in N+1; cpu_done=1 and cpu_rdata=16'hBEEF in N+3; dbg_* outputs stay 0.
- dbg write then CPU read: dbg writes 16'h1234 to 16'h0005 -> mem_we=1 in N+1, dbg_done in N+3; then CPU reads 16'h0005 -> cpu_rdata=16'h1234.
- Simultaneous requests, counter 0: cpu_req=dbg_req=1 -> CPU granted first; dbg granted 3 cycles later once CPU drops req.
- Starvation: dbg_req held high while the CPU issues back-to-back reads -> 4 CPU grants, then the 5th decision grants dbg even with cpu_req=1; starve_cnt returns to 0.
- Reset mid-op: rst=0 during RESP of a CPU read -> next cycle state IDLE, no cpu_done, all outputs 0; a fresh request after rst=1 completes normally.
- Wrap address and idle: read at 16'hFFFF returns memory content; with no requests for 10 cycles, mem_en stays 0 and no gnt/done pulses occur.

Source files
------------

// File: rtl/punc_mem_arbiter_pkg.sv
// punc_mem_arbiter_pkg: shared encodings for the PUnC memory arbiter.
// State and owner codes plus default bus widths.
package punc_mem_arbiter_pkg;

  localparam int AW_DEF = 16;
  localparam int DW_DEF = 16;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_RESP  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DBG = 1'b1
  } arb_own_t;

endpackage

// File: rtl/punc_starve_counter.sv
// punc_starve_counter: saturating count of CPU wins over a waiting dbg.
// Clear has priority over increment.
module punc_starve_counter
  import punc_mem_arbiter_pkg::*;
#(
  parameter int CW           = 3,
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_limit
);

  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != LIM)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_limit = (r_cnt >= LIM);

endmodule

// File: rtl/punc_mem_arbiter.sv
// punc_mem_arbiter: shares the single-port LC3 memory between CPU and dbg.
// One access in flight; CPU priority with a starvation guard for dbg.
module punc_mem_arbiter
  import punc_mem_arbiter_pkg::*;
#(
  parameter int AW           = AW_DEF,
  parameter int DW           = DW_DEF,
  parameter int STARVE_LIMIT = 4,
  parameter int CW           = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_done,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_done,
  output logic [DW-1:0] dbg_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  arb_state_t    r_state;
  arb_own_t      r_own;
  logic          r_is_wr;
  logic          r_cpu_gnt, r_dbg_gnt;
  logic          r_cpu_done, r_dbg_done;
  logic          r_mem_en, r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic [DW-1:0] r_cpu_rdata, r_dbg_rdata;

  logic          w_idle, w_start, w_limit;
  logic          w_inc, w_clr;
  arb_own_t      w_own;
  logic          w_we;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;

  assign w_idle  = (r_state == ARB_IDLE);
  assign w_start = w_idle && (cpu_req || dbg_req);
  assign w_own   = (dbg_req && (!cpu_req || w_limit)) ? OWN_DBG : OWN_CPU;
  assign w_we    = (w_own == OWN_DBG) ? dbg_we    : cpu_we;
  assign w_addr  = (w_own == OWN_DBG) ? dbg_addr  : cpu_addr;
  assign w_wdata = (w_own == OWN_DBG) ? dbg_wdata : cpu_wdata;

  // A CPU win only counts as a loss for dbg if dbg was actually waiting.
  assign w_inc = w_start && (w_own == OWN_CPU) && dbg_req;
  assign w_clr = (w_start && (w_own == OWN_DBG)) || (w_idle && !dbg_req);

  punc_starve_counter #(
    .CW          (CW),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk    (clk),
    .rst    (rst),
    .i_inc  (w_inc),
    .i_clr  (w_clr),
    .o_limit(w_limit)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ARB_IDLE;
      r_own       <= OWN_CPU;
      r_is_wr     <= 1'b0;
      r_cpu_gnt   <= 1'b0;
      r_dbg_gnt   <= 1'b0;
      r_cpu_done  <= 1'b0;
      r_dbg_done  <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_rdata <= '0;
      r_dbg_rdata <= '0;
    end else begin
      r_cpu_gnt  <= 1'b0;
      r_dbg_gnt  <= 1'b0;
      r_cpu_done <= 1'b0;
      r_dbg_done <= 1'b0;
      r_mem_en   <= 1'b0;
      r_mem_we   <= 1'b0;
      unique case (r_state)
        ARB_IDLE: begin
          if (w_start) begin
            r_own       <= w_own;
            r_is_wr     <= w_we;
            r_mem_en    <= 1'b1;
            r_mem_we    <= w_we;
            r_mem_addr  <= w_addr;
            r_mem_wdata <= w_wdata;
            r_cpu_gnt   <= (w_own == OWN_CPU);
            r_dbg_gnt   <= (w_own == OWN_DBG);
            r_state     <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          r_state <= ARB_RESP;
        end
        ARB_RESP: begin
          if (!r_is_wr && (r_own == OWN_CPU)) r_cpu_rdata <= mem_rdata;
          if (!r_is_wr && (r_own == OWN_DBG)) r_dbg_rdata <= mem_rdata;
          r_cpu_done <= (r_own == OWN_CPU);
          r_dbg_done <= (r_own == OWN_DBG);
          r_state    <= ARB_IDLE;
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

  assign cpu_gnt   = r_cpu_gnt;
  assign dbg_gnt   = r_dbg_gnt;
  assign cpu_done  = r_cpu_done;
  assign dbg_done  = r_dbg_done;
  assign cpu_rdata = r_cpu_rdata;
  assign dbg_rdata = r_dbg_rdata;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule
